// File: rtl/hazard_controller.sv
// Purpose : pipeline hazard unit (load-use / branch / divide stalls, D-stage forwarding, flushes).
// Latency : stall, flush and forward outputs are combinational; divide FSM and stall counter are registered.
// Backpressure: StallF/StallD hold the front end and FlushE injects a bubble while any hazard is present.
module hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic        PCSrcD,
    input  logic        DivD,
    input  logic        HiLoReadD,
    input  logic        DivStartE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        DivBusy,
    output logic        DivDone,
    output logic [15:0] StallCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [4:0] div_cnt;
    logic       e_hits_d;
    logic       m_hits_d;
    logic       lwstall;
    logic       branchstall;
    logic       divstall;
    logic       stall;

    assign DivBusy = (state != IDLE);
    assign DivDone = (state == DONE);

    // Hazard detection; register 0 never creates a dependency, and reset masks everything.
    always_comb begin
        e_hits_d    = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
        m_hits_d    = (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
        lwstall     = MemtoRegE && RegWriteE && e_hits_d;
        branchstall = BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d));
        divstall    = (HiLoReadD || DivD) && (DivBusy || DivStartE);
        stall       = !reset && (lwstall || branchstall || divstall);
    end

    // Pipeline control outputs; a stall wins over a redirect so the held instruction is not lost.
    always_comb begin
        StallF    = stall;
        StallD    = stall;
        FlushE    = reset || stall;
        FlushD    = !reset && (PCSrcD || JumpD) && !stall;
        ForwardAD = !reset && (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD = !reset && (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
    end

    // Divide sequencer: 32 BUSY cycles then a single DONE cycle; new starts ignored while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (DivStartE) begin
                        state   <= BUSY;
                        div_cnt <= 5'd31;
                    end
                end
                BUSY: begin
                    if (div_cnt == 5'd0) begin
                        state <= DONE;
                    end else begin
                        div_cnt <= div_cnt - 5'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    div_cnt <= 5'd0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles; overlapping hazards count once.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= 16'd0;
        end else if (stall && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk  input  1  single clock, rising edge.
REQ-002 SHALL have port reset  input  1  synchronous active-high reset.
REQ-003 SHALL have inputs RsD, RtD  5 each  source registers of the instruction in Decode.
REQ-004 SHALL have inputs WriteRegE, WriteRegM  5 each  destination registers in Execute and Memory.
REQ-005 SHALL have inputs RegWriteE, RegWriteM, MemtoRegE, MemtoRegM  1 each  write-enable and load flags for E and M.
REQ-006 SHALL have inputs BranchD, JumpD, PCSrcD  1 each  branch in D, jump in D, branch taken (resolved in D).
REQ-007 SHALL have inputs DivD, HiLoReadD, DivStartE  1 each  mult/div in D, mfhi/mflo in D, mult/div issuing in E.
REQ-008 SHALL have outputs StallF, StallD, FlushD, FlushE  1 each  pipeline register stall/clear controls.
REQ-009 SHALL have outputs ForwardAD, ForwardBD  1 each  select ALUOutM for the D-stage branch comparator.
REQ-010 SHALL have outputs DivBusy  1  (state != IDLE) and DivDone  1  (state == DONE).
REQ-011 SHALL have output StallCount  16  saturating count of stalled cycles.

Function
REQ-012 SHALL compute ForwardAD = (RsD != 0) && (RsD == WriteRegM) && RegWriteM; ForwardBD is identical with RtD.
REQ-013 SHALL compute lwstall = MemtoRegE && RegWriteE && (WriteRegE != 0) && (WriteRegE == RsD || WriteRegE == RtD).
REQ-014 SHALL compute branchstall = BranchD && ((RegWriteE && WriteRegE != 0 && WriteRegE matches RsD or RtD) || (MemtoRegM && WriteRegM != 0 && WriteRegM matches RsD or RtD)).
REQ-015 SHALL implement a divide sequencer FSM with states IDLE, BUSY, DONE.
REQ-016 IDLE -> BUSY on a clock edge with DivStartE=1; the 5-bit down-counter loads 31.
REQ-017 In BUSY, the counter SHALL decrement each cycle; BUSY -> DONE on the edge where the counter equals 0, giving exactly 32 BUSY cycles.
REQ-018 DONE -> IDLE unconditionally after one cycle; a DivStartE in DONE or BUSY SHALL be ignored and SHALL NOT reload the counter.
REQ-019 SHALL compute divstall = (HiLoReadD || DivD) && (DivBusy || DivStartE).
REQ-020 SHALL drive StallF = StallD = FlushE = lwstall || branchstall || divstall, combinationally, in the same cycle.
REQ-021 SHALL drive FlushD = (PCSrcD || JumpD) && !StallD; a stall SHALL take priority over a redirect flush.
REQ-022 SHALL increment StallCount on every clock edge with StallD=1; at 16'hFFFF it SHALL hold.
REQ-023 Simultaneous lwstall and divstall SHALL count as one stalled cycle.

Reset
REQ-024 While reset=1: StallF=StallD=FlushD=0, FlushE=1, ForwardAD=ForwardBD=0.
REQ-025 On a clock edge with reset=1: FSM -> IDLE, counter -> 0, StallCount -> 0; DivBusy=DivDone=0 from the next cycle.
REQ-026 Reset asserted in BUSY SHALL abort the sequence with no DivDone pulse.

Verification
REQ-027 Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=8, RsD=8 -> StallF=StallD=FlushE=1 for exactly one cycle; StallCount +1.
REQ-028 Zero register: the REQ-027 stimulus with WriteRegE=0, RsD=0 -> no stall; ForwardAD=0 with WriteRegM=0.
REQ-029 Branch: BranchD=1, RtD=9, RegWriteE=1, WriteRegE=9 -> stall; the next cycle, WriteRegM=9 with RegWriteM=1 and no load -> ForwardBD=1 and no stall.
REQ-030 Divide: DivStartE pulse, then mfhi held in D -> DivBusy=1 for 33 cycles, DivDone=1 on cycle 33 only, HiLoReadD stalled for 33 cycles plus the issue cycle, and released when the FSM is IDLE.
REQ-031 Priority: PCSrcD=1 together with lwstall -> FlushD=0, StallD=1; the following cycle, with the stall cleared -> FlushD=1.
REQ-032 Reset mid-BUSY at count 10 -> DivBusy=0 the next cycle, no DivDone, and StallCount=0.
